// File: rtl/lcd_text_controller.sv
// HD44780-class character-LCD controller (8-bit, write-only).
// Keeps a host-writable text buffer and refreshes it to the panel forever after init.
module lcd_text_controller #(
    parameter int NUM_ROWS          = 2,
    parameter int NUM_COLS          = 16,
    parameter int POWERON_CYCLES    = 2_000_000,
    parameter int E_CYCLES          = 25,
    parameter int WAIT_CYCLES       = 2_500,
    parameter int CLEAR_WAIT_CYCLES = 100_000,
    parameter int ADDR_W            = $clog2(NUM_ROWS*NUM_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              rs,
    output logic              rw,
    output logic              enable,
    output logic [7:0]        data,
    output logic              init_done,
    output logic              frame_done
);
    localparam int DEPTH = NUM_ROWS * NUM_COLS;
    localparam logic [ADDR_W:0]   LP_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [4:0]        LAST_COL  = 5'(NUM_COLS - 1);
    localparam logic [1:0]        LAST_ROW  = 2'(NUM_ROWS - 1);

    typedef enum logic [1:0] {ST_POWERON, ST_INIT, ST_SET_ADDR, ST_WRITE_CHAR} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_SETTLE} phase_t;

    state_t            r_state;
    phase_t            r_phase;
    logic [31:0]       r_cnt;
    logic [1:0]        r_init_idx;
    logic [1:0]        r_row;
    logic [4:0]        r_col;
    logic [ADDR_W-1:0] r_char_addr;
    logic              r_rs;
    logic              r_data_is_char;
    logic [7:0]        r_cmd;
    logic [7:0]        r_rd_data;

    logic [7:0] r_mem [DEPTH] = '{default: 8'h20};

    logic        w_long_wait;
    logic [31:0] w_settle_limit;
    logic        w_launch;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_next_is_char;
    logic [7:0]  w_next_cmd;
    logic        w_char_rd;
    logic        w_wr_ok;
    logic [ADDR_W-1:0] w_char_addr_inc;

    function automatic logic [7:0] f_row_cmd(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h80 + 8'(NUM_COLS);
            default: return 8'hC0 + 8'(NUM_COLS);
        endcase
    endfunction

    function automatic logic [7:0] f_init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return (NUM_ROWS == 1) ? 8'h30 : 8'h38;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // A launch is the edge that opens the SETUP cycle of the next transfer.
    always_comb begin
        w_long_wait     = (r_state == ST_INIT) && (r_init_idx == 2'd3);
        w_settle_limit  = w_long_wait ? 32'(CLEAR_WAIT_CYCLES - 1) : 32'(WAIT_CYCLES - 1);
        w_launch        = (r_state == ST_POWERON) ? (r_cnt == 32'(POWERON_CYCLES - 1))
                                                  : ((r_phase == PH_SETTLE) && (r_cnt == w_settle_limit));
        w_last_col      = (r_col == LAST_COL);
        w_last_row      = (r_row == LAST_ROW);
        w_next_is_char  = (r_state == ST_SET_ADDR) || ((r_state == ST_WRITE_CHAR) && !w_last_col);
        w_char_rd       = w_launch && w_next_is_char;
        w_wr_ok         = ({1'b0, wr_addr} < LP_DEPTH);
        w_char_addr_inc = (r_char_addr == LAST_ADDR) ? '0 : r_char_addr + 1'b1;
        w_next_cmd      = 8'h00;
        case (r_state)
            ST_POWERON:    w_next_cmd = f_init_cmd(2'd0);
            ST_INIT:       w_next_cmd = (r_init_idx == 2'd3) ? f_row_cmd(2'd0)
                                                             : f_init_cmd(r_init_idx + 2'd1);
            ST_WRITE_CHAR: w_next_cmd = f_row_cmd(w_last_row ? 2'd0 : r_row + 2'd1);
            default:       w_next_cmd = 8'h00;
        endcase
    end

    // Read-before-write: a write in the SETUP cycle reaches the panel next pass.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok)
            r_mem[wr_addr] <= wr_data;
        if (w_char_rd)
            r_rd_data <= r_mem[r_char_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_POWERON;
            r_phase        <= PH_SETUP;
            r_cnt          <= '0;
            r_init_idx     <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_char_addr    <= '0;
            r_rs           <= 1'b0;
            r_data_is_char <= 1'b0;
            r_cmd          <= 8'h00;
            enable         <= 1'b0;
            init_done      <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_launch) begin
                r_phase        <= PH_SETUP;
                r_cnt          <= '0;
                enable         <= 1'b0;
                r_rs           <= w_next_is_char;
                r_data_is_char <= w_next_is_char;
                if (!w_next_is_char)
                    r_cmd <= w_next_cmd;
                case (r_state)
                    ST_POWERON: begin
                        r_state    <= ST_INIT;
                        r_init_idx <= 2'd0;
                    end
                    ST_INIT: begin
                        if (r_init_idx == 2'd3) begin
                            r_state   <= ST_SET_ADDR;
                            r_row     <= 2'd0;
                            init_done <= 1'b1;
                        end else begin
                            r_init_idx <= r_init_idx + 2'd1;
                        end
                    end
                    ST_SET_ADDR: begin
                        r_state     <= ST_WRITE_CHAR;
                        r_col       <= 5'd0;
                        r_char_addr <= w_char_addr_inc;
                    end
                    default: begin
                        if (w_last_col) begin
                            r_col   <= 5'd0;
                            r_state <= ST_SET_ADDR;
                            if (w_last_row) begin
                                r_row      <= 2'd0;
                                frame_done <= 1'b1;
                            end else begin
                                r_row <= r_row + 2'd1;
                            end
                        end else begin
                            r_col       <= r_col + 5'd1;
                            r_char_addr <= w_char_addr_inc;
                        end
                    end
                endcase
            end else if (r_state == ST_POWERON) begin
                r_cnt <= r_cnt + 32'd1;
            end else begin
                case (r_phase)
                    PH_SETUP: begin
                        r_phase <= PH_PULSE;
                        enable  <= 1'b1;
                        r_cnt   <= '0;
                    end
                    PH_PULSE: begin
                        if (r_cnt == 32'(E_CYCLES - 1)) begin
                            r_phase <= PH_SETTLE;
                            enable  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    default: r_cnt <= r_cnt + 32'd1;
                endcase
            end
        end
    end

    assign rs   = r_rs;
    assign rw   = 1'b0;
    assign data = r_data_is_char ? r_rd_data : r_cmd;

endmodule
